// File: rtl/openfifo_rd_pkg.sv
// Shared types for the open FIFO read side.
// Holds the reader state enum and the output buffer depth.
package openfifo_rd_pkg;

  typedef enum logic {
    RD_RUN,
    RD_FLUSH
  } rd_state_e;

  localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/openfifo4_reader_if.sv
// FIFO-side and downstream handshake bundle for the reader.
// master: reader (drives single_pop, out_valid, out_data); slave: environment.
interface openfifo4_reader_if #(
  parameter int DWIDTH = 32
);

  logic [DWIDTH-1:0] fifo_outData;
  logic              fifo_empty;
  logic              single_pop;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;

  modport master (
    input  fifo_outData,
    input  fifo_empty,
    input  out_ready,
    output single_pop,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_outData,
    output fifo_empty,
    output out_ready,
    input  single_pop,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/openfifo_rd_skid2.sv
// Two-entry ordered buffer (main + skid) with push/accept/clear.
// Ports: clk, rst, push, push_data, accept, clear -> occ, head (= main).
module openfifo_rd_skid2
  import openfifo_rd_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              accept,
  input  logic              clear,
  output logic [1:0]        occ,
  output logic [DWIDTH-1:0] head
);

  logic [DWIDTH-1:0] skid;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= '0;
      head <= '0;
      skid <= '0;
    end else if (clear) begin
      occ <= '0;
    end else begin
      unique case (occ)
        2'd0: begin
          if (push) begin
            head <= push_data;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && accept) begin
            head <= push_data;
          end else if (push) begin
            skid <= push_data;
            occ  <= 2'd2;
          end else if (accept) begin
            occ <= 2'd0;
          end
        end
        2'(RD_BUF_DEPTH): begin
          // older skid entry always moves up before a newer push
          if (accept) begin
            head <= skid;
            if (push) begin
              skid <= push_data;
            end else begin
              occ <= 2'd1;
            end
          end
        end
        default: occ <= '0;
      endcase
    end
  end

endmodule

// File: rtl/openfifo4_reader.sv
// Read-side consumer of the 4-entry open FIFO with flush and halt.
// Ports: clk, rst, bus (FIFO + downstream), halt, flush -> flushing, busy, drop_cnt.
module openfifo4_reader
  import openfifo_rd_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  openfifo4_reader_if.master  bus,
  input  logic                halt,
  input  logic                flush,
  output logic                flushing,
  output logic                busy,
  output logic [CWIDTH-1:0]   drop_cnt
);

  localparam logic [CWIDTH+1:0] DropMax = {2'b00, {CWIDTH{1'b1}}};

  rd_state_e         state;
  logic [1:0]        occ;
  logic [DWIDTH-1:0] head;
  logic [CWIDTH-1:0] dropCnt;
  logic [CWIDTH-1:0] dropNext;
  logic [CWIDTH+1:0] dropSum;
  logic [1:0]        bufDrop;
  logic              accept;
  logic              popRun;
  logic              pop;
  logic              push;
  logic              clearBuf;
  logic              flushPop;

  // pop decision uses only flops and inputs; out_ready stays out of it
  always_comb begin
    accept   = (occ != 2'd0) & bus.out_ready;
    popRun   = !bus.fifo_empty & !halt
             & (occ < 2'(RD_BUF_DEPTH)) & !flush;
    pop      = 1'b0;
    unique case (state)
      RD_RUN:   pop = popRun;
      RD_FLUSH: pop = !bus.fifo_empty;
      default:  pop = 1'b0;
    endcase
    push     = (state == RD_RUN) & popRun;
    clearBuf = (state == RD_RUN) & flush;
    flushPop = (state == RD_FLUSH) & pop;
    bufDrop  = clearBuf ? (occ - {1'b0, accept}) : 2'd0;
    dropSum  = {2'b00, dropCnt}
             + {{CWIDTH{1'b0}}, bufDrop}
             + {{(CWIDTH + 1){1'b0}}, flushPop};
    dropNext = (dropSum > DropMax) ? {CWIDTH{1'b1}}
                                   : dropSum[CWIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RD_RUN;
      dropCnt <= '0;
    end else begin
      dropCnt <= dropNext;
      unique case (state)
        RD_RUN: begin
          if (flush) state <= RD_FLUSH;
        end
        RD_FLUSH: begin
          if (bus.fifo_empty && !pop) state <= RD_RUN;
        end
        default: state <= RD_RUN;
      endcase
    end
  end

  openfifo_rd_skid2 #(
    .DWIDTH(DWIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(bus.fifo_outData),
    .accept   (accept),
    .clear    (clearBuf),
    .occ      (occ),
    .head     (head)
  );

  assign bus.single_pop = pop;
  assign bus.out_valid  = (occ != 2'd0);
  assign bus.out_data   = head;
  assign flushing       = (state == RD_FLUSH);
  assign busy           = (state != RD_RUN) | (occ != 2'd0);
  assign drop_cnt       = dropCnt;

  noPopWhenEmpty: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.single_pop && bus.fifo_empty)
  );

endmodule

// File: tb/tb_openfifo4_reader.sv
// Directed bench for openfifo4_reader with a flopped-empty FIFO model.
// A second instance with CWIDTH=2 covers drop counter saturation.
module tb_openfifo4_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        flush = 1'b0;
  logic        outReady = 1'b0;
  logic        flushing;
  logic        busy;
  logic [7:0]  dropCnt;

  logic        halt2 = 1'b1;
  logic        flush2 = 1'b0;
  logic        fEmpty2 = 1'b1;
  logic        flushing2;
  logic        busy2;
  logic [1:0]  drop2;

  logic        fEmpty = 1'b1;
  logic [31:0] fData = 32'h0;
  logic [31:0] fmem [16];
  logic [3:0]  wrPtr = 4'd0;
  logic [3:0]  rdPtr = 4'd0;
  int          popEmptyErr = 0;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  openfifo4_reader_if #(.DWIDTH(32)) bus ();
  openfifo4_reader_if #(.DWIDTH(32)) bus2 ();

  assign bus.fifo_empty    = fEmpty;
  assign bus.fifo_outData  = fData;
  assign bus.out_ready     = outReady;
  assign bus2.fifo_empty   = fEmpty2;
  assign bus2.fifo_outData = 32'h0;
  assign bus2.out_ready    = 1'b1;

  openfifo4_reader #(.DWIDTH(32), .CWIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .halt    (halt),
    .flush   (flush),
    .flushing(flushing),
    .busy    (busy),
    .drop_cnt(dropCnt)
  );

  openfifo4_reader #(.DWIDTH(32), .CWIDTH(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2),
    .halt    (halt2),
    .flush   (flush2),
    .flushing(flushing2),
    .busy    (busy2),
    .drop_cnt(drop2)
  );

  // FIFO model: empty flag and head data are registered
  always @(posedge clk) begin
    if (bus.single_pop && fEmpty) popEmptyErr <= popEmptyErr + 1;
    rdPtr  <= 4'(rdPtr + 4'(bus.single_pop));
    fEmpty <= (wrPtr == 4'(rdPtr + 4'(bus.single_pop)));
    fData  <= fmem[4'(rdPtr + 4'(bus.single_pop))];
  end

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wrPtr] = base + 32'(i);
      wrPtr = wrPtr + 4'd1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nCmp++;
    if (bus.out_valid !== 1'b0) begin
      nErr++; $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    end
    nCmp++;
    if (bus.out_data !== 32'h0) begin
      nErr++; $display("FAIL reset_data: got %h want 0", bus.out_data);
    end
    nCmp++;
    if (bus.single_pop !== 1'b0) begin
      nErr++; $display("FAIL reset_pop: got %b want 0", bus.single_pop);
    end
    nCmp++;
    if (dropCnt !== 8'd0) begin
      nErr++; $display("FAIL reset_drop: got %0d want 0", dropCnt);
    end
    nCmp++;
    if (flushing !== 1'b0 || busy !== 1'b0) begin
      nErr++; $display("FAIL reset_flags: got %b%b want 00", flushing, busy);
    end
    nCmp++;
    if (drop2 !== 2'd0 || flushing2 !== 1'b0) begin
      nErr++; $display("FAIL reset_dut2: got %0d/%b want 0/0", drop2, flushing2);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic expPop, expValid;
    outReady = 1'b1;
    load(32'hA000_0000, 4);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      expPop   = (i < 4);
      expValid = (i >= 1) && (i <= 4);
      nCmp++;
      if (bus.single_pop !== expPop) begin
        nErr++;
        $display("FAIL stream_pop[%0d]: got %b want %b", i, bus.single_pop, expPop);
      end
      nCmp++;
      if (bus.out_valid !== expValid) begin
        nErr++;
        $display("FAIL stream_valid[%0d]: got %b want %b", i, bus.out_valid, expValid);
      end
      if (expValid) begin
        nCmp++;
        if (bus.out_data !== 32'hA000_0000 + 32'(i - 1)) begin
          nErr++;
          $display("FAIL stream_data[%0d]: got %h want %h",
                   i, bus.out_data, 32'hA000_0000 + 32'(i - 1));
        end
      end
    end
    nCmp++;
    if (busy !== 1'b0) begin
      nErr++; $display("FAIL stream_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int nPops = 0;
    int idx = 0;
    outReady = 1'b0;
    load(32'hB000_0000, 4);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.single_pop === 1'b1) nPops++;
      if (bus.out_valid === 1'b1) begin
        nCmp++;
        if (bus.out_data !== 32'hB000_0000) begin
          nErr++;
          $display("FAIL bp_hold[%0d]: got %h want B0000000", i, bus.out_data);
        end
      end
    end
    nCmp++;
    if (nPops != 2) begin
      nErr++; $display("FAIL bp_pops: got %0d want 2", nPops);
    end
    nCmp++;
    if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
      nErr++; $display("FAIL bp_full: got v=%b b=%b want 1/1", bus.out_valid, busy);
    end
    outReady = 1'b1;
    for (int c = 0; c < 12 && idx < 4; c++) begin
      if (bus.out_valid === 1'b1) begin
        nCmp++;
        if (bus.out_data !== 32'hB000_0000 + 32'(idx)) begin
          nErr++;
          $display("FAIL bp_order[%0d]: got %h want %h",
                   idx, bus.out_data, 32'hB000_0000 + 32'(idx));
        end
        idx++;
      end
      @(posedge clk); #1;
    end
    nCmp++;
    if (idx != 4) begin
      nErr++; $display("FAIL bp_count: got %0d want 4", idx);
    end
    nCmp++;
    if (popEmptyErr != 0) begin
      nErr++; $display("FAIL bp_pop_empty: got %0d want 0", popEmptyErr);
    end
    nCmp++;
    if (busy !== 1'b0) begin
      nErr++; $display("FAIL bp_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_halt();
    int idx = 0;
    halt = 1'b1;
    load(32'hC000_0000, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      nCmp++;
      if (bus.single_pop !== 1'b0 || bus.out_valid !== 1'b0) begin
        nErr++;
        $display("FAIL halt_hold[%0d]: got p=%b v=%b want 0/0",
                 i, bus.single_pop, bus.out_valid);
      end
    end
    halt = 1'b0;
    for (int c = 0; c < 12 && idx < 3; c++) begin
      if (bus.out_valid === 1'b1) begin
        nCmp++;
        if (bus.out_data !== 32'hC000_0000 + 32'(idx)) begin
          nErr++;
          $display("FAIL halt_order[%0d]: got %h want %h",
                   idx, bus.out_data, 32'hC000_0000 + 32'(idx));
        end
        idx++;
      end
      @(posedge clk); #1;
    end
    nCmp++;
    if (idx != 3 || busy !== 1'b0) begin
      nErr++; $display("FAIL halt_drain: got n=%0d b=%b want 3/0", idx, busy);
    end
  endtask

  task automatic test_flush();
    outReady = 1'b0;
    load(32'hD000_0000, 4);
    repeat (3) @(posedge clk);
    #1;
    nCmp++;
    if (bus.single_pop !== 1'b0 || bus.out_data !== 32'hD000_0000) begin
      nErr++;
      $display("FAIL flush_pre: got p=%b d=%h want 0/D0000000",
               bus.single_pop, bus.out_data);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    nCmp++;
    if (bus.out_valid !== 1'b0 || flushing !== 1'b1) begin
      nErr++;
      $display("FAIL flush_enter: got v=%b f=%b want 0/1", bus.out_valid, flushing);
    end
    nCmp++;
    if (bus.single_pop !== 1'b1 || dropCnt !== 8'd2) begin
      nErr++;
      $display("FAIL flush_c1: got p=%b d=%0d want 1/2", bus.single_pop, dropCnt);
    end
    @(posedge clk); #1;
    nCmp++;
    if (bus.single_pop !== 1'b1 || dropCnt !== 8'd3) begin
      nErr++;
      $display("FAIL flush_c2: got p=%b d=%0d want 1/3", bus.single_pop, dropCnt);
    end
    @(posedge clk); #1;
    nCmp++;
    if (bus.fifo_empty !== 1'b1 || bus.single_pop !== 1'b0 || flushing !== 1'b1) begin
      nErr++;
      $display("FAIL flush_tail: got e=%b p=%b f=%b want 1/0/1",
               bus.fifo_empty, bus.single_pop, flushing);
    end
    @(posedge clk); #1;
    nCmp++;
    if (flushing !== 1'b0 || dropCnt !== 8'd4 || busy !== 1'b0) begin
      nErr++;
      $display("FAIL flush_exit: got f=%b d=%0d b=%b want 0/4/0",
               flushing, dropCnt, busy);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] expDrop;
    for (int k = 0; k < 2; k++) begin
      expDrop = (k == 0) ? 2'd2 : 2'd3;
      @(posedge clk); #1;
      flush2 = 1'b1;
      @(posedge clk); #1;
      flush2  = 1'b0;
      fEmpty2 = 1'b0;
      nCmp++;
      if (flushing2 !== 1'b1) begin
        nErr++; $display("FAIL sat_enter[%0d]: got %b want 1", k, flushing2);
      end
      repeat (2) @(posedge clk);
      #1;
      fEmpty2 = 1'b1;
      @(posedge clk); #1;
      nCmp++;
      if (flushing2 !== 1'b0 || drop2 !== expDrop) begin
        nErr++;
        $display("FAIL sat_drop[%0d]: got f=%b d=%0d want 0/%0d",
                 k, flushing2, drop2, expDrop);
      end
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    outReady = 1'b0;
    halt = 1'b1;
    load(32'hE000_0000, 3);
    repeat (2) @(posedge clk);
    #1;
    halt = 1'b0;
    @(posedge clk); #1;
    halt  = 1'b1;
    flush = 1'b1;
    nCmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hE000_0000) begin
      nErr++;
      $display("FAIL rm_occ1: got v=%b d=%h want 1/E0000000",
               bus.out_valid, bus.out_data);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    nCmp++;
    if (flushing !== 1'b1 || dropCnt !== 8'd5 || bus.single_pop !== 1'b1) begin
      nErr++;
      $display("FAIL rm_flush: got f=%b d=%0d p=%b want 1/5/1",
               flushing, dropCnt, bus.single_pop);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    nCmp++;
    if (flushing !== 1'b0 || bus.out_valid !== 1'b0) begin
      nErr++;
      $display("FAIL rm_state: got f=%b v=%b want 0/0", flushing, bus.out_valid);
    end
    nCmp++;
    if (dropCnt !== 8'd0 || bus.single_pop !== 1'b0 || busy !== 1'b0) begin
      nErr++;
      $display("FAIL rm_clear: got d=%0d p=%b b=%b want 0/0/0",
               dropCnt, bus.single_pop, busy);
    end
    rst = 1'b0;
    halt = 1'b0;
    outReady = 1'b1;
    for (int c = 0; c < 8 && idx < 1; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        nCmp++;
        if (bus.out_data !== 32'hE000_0002) begin
          nErr++;
          $display("FAIL rm_resume: got %h want E0000002", bus.out_data);
        end
        idx++;
      end
    end
    nCmp++;
    if (idx != 1) begin
      nErr++; $display("FAIL rm_resume_count: got %0d want 1", idx);
    end
    nCmp++;
    if (popEmptyErr != 0) begin
      nErr++; $display("FAIL pop_when_empty: got %0d want 0", popEmptyErr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_halt();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
